mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
Parametrised multicycle control unit for the 8-bit-datapath MIPS subset; successor to the fixed four-fetch-state controller.
- Fetch beat count is a parameter, so the same controller serves 8-, 16- and 32-bit instruction memories.
- Memory states honour a ready handshake (wait states).
- Adds ADDI and BNE, plus illegal-opcode reporting.
- Sits between the instruction register opcode field and the datapath mux/enable controls.

Parameters:
FETCH_BEATS, 4, instruction fetch cycles per instruction (legal 1, 2, 4); width of irwrite
WAIT_EN, 1, 1: FETCH/LBRD/SBWR stall until mem_ready; 0: mem_ready ignored (treated as 1)
EXT_EN, 1, 1: ADDI and BNE decoded; 0: both treated as illegal

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  6  opcode from instruction register
mem_ready  in  1  memory accepts/returns data this cycle
memread  out  1  memory read strobe
memwrite  out  1  memory write strobe
iord  out  1  address mux: 0 = PC, 1 = ALU out
alusrca  out  1  ALU A select
alusrcb  out  2  ALU B select
aluop  out  2  00 add, 01 sub, 10 funct
memtoreg  out  1  register writeback select
regdst  out  1  destination: 0 = rt, 1 = rd
regwrite  out  1  register file write enable
pcwrite  out  1  unconditional PC write
brnch  out  1  conditional branch enable
brne  out  1  branch sense: 0 = on zero, 1 = on not-zero
pcsrc  out  2  00 ALU, 01 ALUOut, 10 jump target
irwrite  out  FETCH_BEATS  one-hot instruction-register byte-lane enable
illegal_op  out  1  one-cycle pulse in DECODE on unsupported opcode

Behaviour:
- Reset: async, active-high. State becomes FETCH, beat counter 0. While reset is high, every output is forced 0 combinationally. First FETCH outputs appear in the first cycle after reset deasserts.
- States (enum in package): FETCH, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, BNEEX, ADDIEX, ADDIWR, JEX.
- Defaults: all outputs 0 in every state unless listed. Outputs decode from state, beat and mem_ready (mem_ready only in stall states).
- Accept: acc = mem_ready | ~WAIT_EN.
- FETCH, beat b:
  - memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - If acc: irwrite=1<<b, pcwrite=1. Beat then increments; when b==FETCH_BEATS-1, go to DECODE with beat=0.
  - If !acc: irwrite=0, pcwrite=0, hold state and beat.
- DECODE (1 cycle): alusrcb=11. Next state by op:
  - LB 100000 / SB 101000 -> MEMADR
  - RTYPE 000000 -> RTYPEEX
  - BEQ 000100 -> BEQEX
  - BNE 000101 -> BNEEX (EXT_EN)
  - ADDI 001000 -> ADDIEX (EXT_EN)
  - J 000010 -> JEX
  - Anything else -> FETCH with illegal_op=1 for this cycle only.
- MEMADR: alusrca=1, alusrcb=10. Next is SBWR if op==SB, else LBRD.
- LBRD: memread=1, iord=1. acc -> LBWR; else hold.
- LBWR: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
- SBWR: memwrite=1, iord=1, held until acc. acc -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 -> RTYPEWR.
- RTYPEWR: regwrite=1, regdst=1 -> FETCH.
- BEQEX: alusrca=1, aluop=01, brnch=1, pcsrc=01 -> FETCH.
- BNEEX: same as BEQEX plus brne=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWR.
- ADDIWR: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- JEX: pcwrite=1, pcsrc=10 -> FETCH.
- Latency with no stalls, in cycles from first FETCH beat to next FETCH:
  - LB: F+4
  - SB, RTYPE, ADDI: F+3
  - BEQ, BNE, J: F+2
  - (F = FETCH_BEATS)
- op is only sampled in DECODE and MEMADR (IR is stable there); changes on op in other states have no effect.
- Reset mid-instruction, including during a stall: state returns to FETCH beat 0. No partial memwrite persists past reset assertion.
- FETCH_BEATS=1: the beat counter is a constant 0, irwrite=1'b1 on accept.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t
  - op_t (LB, SB, RTYPE, BEQ, BNE, ADDI, J)
  - localparams for aluop codes (ALU_ADD, ALU_SUB, ALU_FUNCT)
  - pcsrc codes (PC_ALU, PC_ALUOUT, PC_JUMP)
  - alusrcb codes
- One sub-module, mips_fetch_seq: beat counter plus one-hot irwrite decode. Parametrised by FETCH_BEATS; inputs are enable and acc; outputs are last_beat and irwrite.

Test Plan:
- FETCH_BEATS=4, WAIT_EN=1, mem_ready=1, op=000000 -> irwrite 0001,0010,0100,1000 on consecutive cycles, each with pcwrite=1; DECODE; RTYPEEX aluop=10; RTYPEWR regwrite=1 regdst=1; back in FETCH at cycle 7.
- Same config, LB op=100000, mem_ready low 3 cycles in LBRD -> memread=1 iord=1 held 4 cycles total; LBWR regwrite=1 memtoreg=1 on the cycle after mem_ready=1.
- SB with mem_ready low 2 cycles in FETCH beat 2 -> irwrite=0 pcwrite=0 during stall, beat stays 2. SBWR later asserts memwrite=1 until accept, then FETCH.
- EXT_EN=1: BNE 000101 -> BNEEX with brnch=1 brne=1 pcsrc=01 aluop=01. ADDI 001000 -> ADDIEX alusrcb=10, then ADDIWR regwrite=1 regdst=0.
- EXT_EN=0, op=001000; also op=111111 under any config -> illegal_op=1 for exactly one cycle in DECODE, next state FETCH, no regwrite/memwrite.
- FETCH_BEATS=1, WAIT_EN=0, J op=000010, reset asserted asynchronously mid-JEX -> FETCH/DECODE/JEX = 3 cycles with pcwrite=1 pcsrc=10 in JEX. On reset all outputs drop to 0 immediately (before next edge), then FETCH on release.

Source files
------------

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared types and encodings for the parametrised multicycle MIPS control unit.
// State names, opcodes and the datapath select codes live here so every file agrees on them.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_LBRD, S_LBWR, S_SBWR, S_RTYPEEX,
        S_RTYPEWR, S_BEQEX, S_BNEEX, S_ADDIEX, S_ADDIWR, S_JEX
    } state_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_LB    = 6'b100000,
        OP_SB    = 6'b101000
    } op_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // Every datapath control except the width-parametrised irwrite lane enables.
    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       pcwrite;
        logic       brnch;
        logic       brne;
        logic [1:0] pcsrc;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Bundle between the controller and the datapath: opcode and memory handshake in,
// mux selects and write enables out.
interface mips_mc_ctrl_if #(parameter int FETCH_BEATS = 4);

    logic [5:0]             op;
    logic                   mem_ready;
    logic                   memread;
    logic                   memwrite;
    logic                   iord;
    logic                   alusrca;
    logic [1:0]             alusrcb;
    logic [1:0]             aluop;
    logic                   memtoreg;
    logic                   regdst;
    logic                   regwrite;
    logic                   pcwrite;
    logic                   brnch;
    logic                   brne;
    logic [1:0]             pcsrc;
    logic [FETCH_BEATS-1:0] irwrite;
    logic                   illegal_op;

    modport master (
        input  op, mem_ready,
        output memread, memwrite, iord, alusrca, alusrcb, aluop, memtoreg,
               regdst, regwrite, pcwrite, brnch, brne, pcsrc, irwrite, illegal_op
    );

    modport slave (
        output op, mem_ready,
        input  memread, memwrite, iord, alusrca, alusrcb, aluop, memtoreg,
               regdst, regwrite, pcwrite, brnch, brne, pcsrc, irwrite, illegal_op
    );

endinterface

// File: rtl/mips_fetch_seq.sv
// Instruction fetch beat counter: walks the IR byte lanes one accepted beat at a time
// and flags the final beat so the controller can move on to DECODE.
module mips_fetch_seq #(
    parameter int FETCH_BEATS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   acc,
    output logic                   last_beat,
    output logic [FETCH_BEATS-1:0] irwrite
);

    localparam int BW = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;

    logic [BW-1:0] beat_q, beat_d;
    logic          advance;

    assign advance   = enable && acc;
    assign last_beat = (beat_q == BW'(FETCH_BEATS - 1));

    // With a single beat last_beat is always true, so the counter never leaves 0.
    always_comb begin
        // NOTE: default first so every path assigns beat_d and no latch is inferred.
        beat_d = beat_q;
        if (advance) beat_d = last_beat ? '0 : beat_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking so the flop captures the pre-edge value of beat_d.
        if (reset) beat_q <= '0;
        else       beat_q <= beat_d;
    end

    assign irwrite = advance ? (FETCH_BEATS'(1) << beat_q) : '0;

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle control FSM for the 8-bit MIPS subset with wait-state handshake,
// optional ADDI/BNE decode and one-cycle illegal-opcode reporting in DECODE.
import mips_ctrl_pkg::*;

module mips_mc_ctrl #(
    parameter int FETCH_BEATS = 4,
    parameter int WAIT_EN     = 1,
    parameter int EXT_EN      = 1
) (
    input  logic            clk,
    input  logic            reset,
    mips_mc_ctrl_if.master  bus
);

    state_t                 state_q, state_d;
    ctrl_t                  ctrl, ctrl_o;
    logic                   acc;
    logic                   last_beat;
    logic [FETCH_BEATS-1:0] irwrite_l;

    assign acc = bus.mem_ready || (WAIT_EN == 0);

    mips_fetch_seq #(.FETCH_BEATS(FETCH_BEATS)) u_fetch (
        .clk       (clk),
        .reset     (reset),
        .enable    (state_q == S_FETCH),
        .acc       (acc),
        .last_beat (last_beat),
        .irwrite   (irwrite_l)
    );

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALU_ADD;
                ctrl.pcsrc   = PC_ALU;
                if (acc) begin
                    ctrl.pcwrite = 1'b1;
                    if (last_beat) state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_BRANCH;
                case (bus.op)
                    OP_LB, OP_SB: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
                    OP_BNE, OP_ADDI: begin
                        if (EXT_EN != 0) begin
                            state_d = (bus.op == OP_BNE) ? S_BNEEX : S_ADDIEX;
                        end else begin
                            ctrl.illegal_op = 1'b1;
                            state_d         = S_FETCH;
                        end
                    end
                    default: begin
                        ctrl.illegal_op = 1'b1;
                        state_d         = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                state_d      = (bus.op == OP_SB) ? S_SBWR : S_LBRD;
            end
            S_LBRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
                if (acc) state_d = S_LBWR;
            end
            S_LBWR: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                state_d       = S_FETCH;
            end
            S_SBWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
                if (acc) state_d = S_FETCH;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = ALU_FUNCT;
                state_d      = S_RTYPEWR;
            end
            S_RTYPEWR: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQEX, S_BNEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALU_SUB;
                ctrl.brnch   = 1'b1;
                ctrl.brne    = (state_q == S_BNEEX);
                ctrl.pcsrc   = PC_ALUOUT;
                state_d      = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALU_ADD;
                state_d      = S_ADDIWR;
            end
            S_ADDIWR: begin
                ctrl.regwrite = 1'b1;
                state_d       = S_FETCH;
            end
            S_JEX: begin
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PC_JUMP;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Reset kills every strobe immediately, including a memwrite caught mid-stall.
    assign ctrl_o = reset ? '0 : ctrl;

    assign bus.memread    = ctrl_o.memread;
    assign bus.memwrite   = ctrl_o.memwrite;
    assign bus.iord       = ctrl_o.iord;
    assign bus.alusrca    = ctrl_o.alusrca;
    assign bus.alusrcb    = ctrl_o.alusrcb;
    assign bus.aluop      = ctrl_o.aluop;
    assign bus.memtoreg   = ctrl_o.memtoreg;
    assign bus.regdst     = ctrl_o.regdst;
    assign bus.regwrite   = ctrl_o.regwrite;
    assign bus.pcwrite    = ctrl_o.pcwrite;
    assign bus.brnch      = ctrl_o.brnch;
    assign bus.brne       = ctrl_o.brne;
    assign bus.pcsrc      = ctrl_o.pcsrc;
    assign bus.illegal_op = ctrl_o.illegal_op;
    assign bus.irwrite    = reset ? '0 : irwrite_l;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench: three controller configurations driven by directed and random
// instruction streams, each compared cycle by cycle against a step-list reference model.
module tb_mips_mc_ctrl;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       pcwrite;
        logic       brnch;
        logic       brne;
        logic [1:0] pcsrc;
        logic       illegal_op;
        logic [3:0] irwrite;
    } obs_t;

    // One micro-step of an instruction as the spec describes it.
    typedef struct {
        obs_t on_acc;
        obs_t on_stall;
        bit   stallable;
        bit   op_live;
        bit   is_fetch;
        bit   is_mem;
        int   beat;
    } step_t;

    localparam logic [5:0] LB = 6'b100000, SB = 6'b101000, RT = 6'b000000,
                           BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                           J = 6'b000010, BAD = 6'b111111;

    int fb_c   [3] = '{4, 2, 1};
    bit wait_c [3] = '{1'b1, 1'b1, 1'b0};
    bit ext_c  [3] = '{1'b1, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op_v  [3];
    logic       rdy_v [3];
    obs_t       obs   [3];
    step_t      plan  [$];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl_if #(.FETCH_BEATS(4)) if0 ();
    mips_mc_ctrl_if #(.FETCH_BEATS(2)) if1 ();
    mips_mc_ctrl_if #(.FETCH_BEATS(1)) if2 ();

    mips_mc_ctrl #(.FETCH_BEATS(4), .WAIT_EN(1), .EXT_EN(1)) dut0 (.clk(clk), .reset(reset), .bus(if0.master));
    mips_mc_ctrl #(.FETCH_BEATS(2), .WAIT_EN(1), .EXT_EN(0)) dut1 (.clk(clk), .reset(reset), .bus(if1.master));
    mips_mc_ctrl #(.FETCH_BEATS(1), .WAIT_EN(0), .EXT_EN(1)) dut2 (.clk(clk), .reset(reset), .bus(if2.master));

    assign if0.op = op_v[0];  assign if0.mem_ready = rdy_v[0];
    assign if1.op = op_v[1];  assign if1.mem_ready = rdy_v[1];
    assign if2.op = op_v[2];  assign if2.mem_ready = rdy_v[2];

    assign obs[0] = {if0.memread, if0.memwrite, if0.iord, if0.alusrca, if0.alusrcb, if0.aluop,
                     if0.memtoreg, if0.regdst, if0.regwrite, if0.pcwrite, if0.brnch, if0.brne,
                     if0.pcsrc, if0.illegal_op, if0.irwrite};
    assign obs[1] = {if1.memread, if1.memwrite, if1.iord, if1.alusrca, if1.alusrcb, if1.aluop,
                     if1.memtoreg, if1.regdst, if1.regwrite, if1.pcwrite, if1.brnch, if1.brne,
                     if1.pcsrc, if1.illegal_op, 2'b00, if1.irwrite};
    assign obs[2] = {if2.memread, if2.memwrite, if2.iord, if2.alusrca, if2.alusrcb, if2.aluop,
                     if2.memtoreg, if2.regdst, if2.regwrite, if2.pcwrite, if2.brnch, if2.brne,
                     if2.pcsrc, if2.illegal_op, 3'b000, if2.irwrite};

    task automatic check(input obs_t act, input obs_t exp, input string tag);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic bit is_legal(input int d, input logic [5:0] op);
        if (op == LB || op == SB || op == RT || op == BEQ || op == J) return 1'b1;
        if (ext_c[d] && (op == BNE || op == ADDI)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input obs_t a, input obs_t s, input bit stl, input bit live, input bit mem);
        step_t st;
        st.on_acc = a; st.on_stall = s; st.stallable = stl; st.op_live = live;
        st.is_fetch = 1'b0; st.is_mem = mem; st.beat = -1;
        plan.push_back(st);
    endtask

    // Expected cycle sequence for one instruction, straight from the opcode table.
    task automatic build(input int d, input logic [5:0] op);
        obs_t  e;
        step_t st;
        plan.delete();
        for (int b = 0; b < fb_c[d]; b++) begin
            e = '0; e.memread = 1'b1; e.alusrcb = 2'b01;
            st.on_stall = e;
            e.irwrite = 4'(1 << b); e.pcwrite = 1'b1;
            st.on_acc = e; st.stallable = 1'b1; st.op_live = 1'b0;
            st.is_fetch = 1'b1; st.is_mem = 1'b0; st.beat = b;
            plan.push_back(st);
        end
        e = '0; e.alusrcb = 2'b11; e.illegal_op = !is_legal(d, op);
        push(e, e, 1'b0, 1'b1, 1'b0);
        if (!is_legal(d, op)) return;
        if (op == LB || op == SB) begin
            e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
            push(e, e, 1'b0, 1'b1, 1'b0);
            if (op == LB) begin
                e = '0; e.memread = 1'b1; e.iord = 1'b1;
                push(e, e, 1'b1, 1'b0, 1'b1);
                e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1;
                push(e, e, 1'b0, 1'b0, 1'b0);
            end else begin
                e = '0; e.memwrite = 1'b1; e.iord = 1'b1;
                push(e, e, 1'b1, 1'b0, 1'b1);
            end
        end else if (op == RT) begin
            e = '0; e.alusrca = 1'b1; e.aluop = 2'b10;
            push(e, e, 1'b0, 1'b0, 1'b0);
            e = '0; e.regwrite = 1'b1; e.regdst = 1'b1;
            push(e, e, 1'b0, 1'b0, 1'b0);
        end else if (op == BEQ || op == BNE) begin
            e = '0; e.alusrca = 1'b1; e.aluop = 2'b01; e.brnch = 1'b1; e.pcsrc = 2'b01;
            e.brne = (op == BNE);
            push(e, e, 1'b0, 1'b0, 1'b0);
        end else if (op == ADDI) begin
            e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
            push(e, e, 1'b0, 1'b0, 1'b0);
            e = '0; e.regwrite = 1'b1;
            push(e, e, 1'b0, 1'b0, 1'b0);
        end else begin
            e = '0; e.pcwrite = 1'b1; e.pcsrc = 2'b10;
            push(e, e, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Called just after a check, still before the next rising edge.
    task automatic do_reset(input int d);
        #2 reset = 1'b1;
        #1 check(obs[d], '0, $sformatf("d%0d_reset_async", d));
        @(posedge clk);
        #1 check(obs[d], '0, $sformatf("d%0d_reset_held", d));
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_instr(input int d, input logic [5:0] op, input int fbeat, input int fn,
                             input int mn, input bit rnd, input int abort);
        int n;
        build(d, op);
        for (int i = 0; i < plan.size(); i++) begin
            n = 0;
            if (plan[i].stallable && wait_c[d]) begin
                if (rnd)                                         n = $urandom_range(0, 2);
                else if (plan[i].is_fetch && plan[i].beat == fbeat) n = fn;
                else if (plan[i].is_mem)                         n = mn;
            end
            for (int k = 0; k < n; k++) begin
                op_v[d]  = plan[i].op_live ? op : 6'($urandom);
                rdy_v[d] = 1'b0;
                #1 check(obs[d], plan[i].on_stall, $sformatf("d%0d_op%b_step%0d_stall%0d", d, op, i, k));
                if (i == abort) begin do_reset(d); return; end
                @(negedge clk);
            end
            op_v[d]  = plan[i].op_live ? op : 6'($urandom);
            rdy_v[d] = (plan[i].stallable && wait_c[d]) ? 1'b1 : 1'($urandom_range(0, 1));
            #1 check(obs[d], plan[i].on_acc, $sformatf("d%0d_op%b_step%0d", d, op, i));
            if (i == abort) begin do_reset(d); return; end
            @(negedge clk);
        end
        rdy_v[d] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic random_stream(input int d, input int count);
        logic [5:0] pool [8];
        pool = '{LB, SB, RT, BEQ, BNE, ADDI, J, BAD};
        for (int t = 0; t < count; t++) begin
            if ($urandom_range(0, 7) == 0) run_instr(d, 6'($urandom), -1, 0, 0, 1'b1, -1);
            else                           run_instr(d, pool[$urandom_range(0, 7)], -1, 0, 0, 1'b1, -1);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin op_v[d] = '0; rdy_v[d] = 1'b0; end
        #1;
        for (int d = 0; d < 3; d++) check(obs[d], '0, $sformatf("d%0d_reset_init", d));
        @(posedge clk);
        @(negedge clk);
        rdy_v[2] = 1'b1;
        #1 check(obs[2], '0, "d2_reset_held_ready");
        reset = 1'b0;

        // Four-beat fetch, wait states, extensions decoded.
        pulse_reset();
        run_instr(0, RT,   -1, 0, 0, 1'b0, -1);
        run_instr(0, LB,   -1, 0, 3, 1'b0, -1);
        run_instr(0, SB,    2, 2, 2, 1'b0, -1);
        run_instr(0, BNE,  -1, 0, 0, 1'b0, -1);
        run_instr(0, ADDI, -1, 0, 0, 1'b0, -1);
        run_instr(0, BAD,   1, 1, 0, 1'b0, -1);
        run_instr(0, BEQ,  -1, 0, 0, 1'b0, -1);
        run_instr(0, J,    -1, 0, 0, 1'b0, -1);
        run_instr(0, SB,   -1, 0, 2, 1'b0, 6);
        run_instr(0, RT,   -1, 0, 0, 1'b0, -1);
        random_stream(0, 25);

        // Two-beat fetch, extensions disabled.
        pulse_reset();
        run_instr(1, ADDI, -1, 0, 0, 1'b0, -1);
        run_instr(1, BNE,  -1, 0, 0, 1'b0, -1);
        run_instr(1, BAD,  -1, 0, 0, 1'b0, -1);
        run_instr(1, LB,    1, 2, 1, 1'b0, -1);
        random_stream(1, 25);

        // Single-beat fetch, mem_ready ignored.
        pulse_reset();
        run_instr(2, J,    -1, 0, 0, 1'b0, -1);
        run_instr(2, J,    -1, 0, 0, 1'b0, 2);
        run_instr(2, LB,   -1, 0, 0, 1'b0, -1);
        run_instr(2, BAD,  -1, 0, 0, 1'b0, -1);
        random_stream(2, 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
